rf_writeback_queue: RTL and testbench
=====================================

# rf_writeback_queue

Buffers register-file write requests from the two CPU result producers (load unit and ALU) and drives the register file's single write port, one write per clock, in arrival order. It also answers two read-address hazard/forwarding queries so that operand reads see data still waiting in the queue. It sits between the execute/memory stages and the register file write port (A3/WD/WE).

## Interface
- N, 5, register address width
- M, 32, data width
- DEPTH, 4, queue entries (power of two, ≥2)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; synchronous, active-low
- ld_valid  in  1  load result request
- ld_addr  in  N  load destination register
- ld_data  in  M  load result
- ld_ready  out  1  load request accepted this cycle when ld_valid && ld_ready
- alu_valid  in  1  ALU result request
- alu_addr  in  N  ALU destination register
- alu_data  in  M  ALU result
- alu_ready  out  1  ALU request accepted when alu_valid && alu_ready
- rf_we  out  1  register file write enable
- rf_a3  out  N  register file write address
- rf_wd  out  M  register file write data
- q_a1, q_a2  in  N  read addresses to check against pending writes
- fwd1_hit, fwd2_hit  out  1  pending write exists for q_a1 / q_a2
- fwd1_data, fwd2_data  out  M  youngest pending data for q_a1 / q_a2
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer: head pointer, tail pointer, count register; entry = {addr, data}.
- free = DEPTH − count (registered count; a same-cycle pop does not raise free).
- ld_ready = (free ≥ 1). alu_ready = (free ≥ 2) || (free == 1 && !ld_valid). Load has priority for the last slot.
- Both accepted same cycle: load entry written at tail, ALU entry at tail+1 (load is older).
- Requests with addr == 0 complete the handshake under the same ready rules but are not stored (register 0 is hardwired zero); count does not change for them.
- Drain: rf_we = (count ≠ 0); rf_a3/rf_wd = head entry (combinational from registers). Head pops on every rising edge where rf_we = 1.
- rf_a3 = 0, rf_wd = 0 when count == 0.
- count_next = count + pushes − pop; pointers wrap modulo DEPTH.
- Forwarding: fwdK_hit = 1 iff q_aK ≠ 0 and some occupied entry has addr == q_aK; fwdK_data = data of the youngest such entry (closest to tail), else 0. Purely combinational over stored entries; same-cycle incoming requests are not forwarded.
- The entry currently at head (being written this edge) still counts for forwarding.

## Timing
- Reset (rst_n = 0 at rising edge): head = tail = count = 0; next cycle rf_we = 0, rf_a3 = 0, rf_wd = 0, fwd*_hit = 0, fwd*_data = 0, count = 0, ld_ready = alu_ready = 1 (subject to rule above). Reset mid-operation discards all pending writes; none reach the register file afterward.
- Latency: request accepted at edge k → present at head after edge k if queue was empty → written into register file at edge k+1 (rf_we high during cycle k..k+1).
- Throughput: one drain per cycle; up to two pushes per cycle.
- Full (count == DEPTH): ld_ready = alu_ready = 0 even if a pop occurs that cycle.
- Push + pop same edge: both take effect; count adjusts by net.
- Write-order guarantee: two writes to the same register reach the register file in acceptance order.

## Test plan
- Reset then idle: hold rst_n = 0 two cycles → rf_we = 0, count = 0, fwd1_hit = 0, both readies = 1.
- Single ALU write: alu_valid, alu_addr = 3, alu_data = 0x0000_00AA at edge k → count = 1, rf_we = 1, rf_a3 = 3, rf_wd = 0xAA in cycle after k; count = 0 after edge k+1.
- Simultaneous push: ld (addr 5, 0x11) and alu (addr 5, 0x22) same edge → rf writes 0x11 then 0x22 on consecutive edges; fwd1_data with q_a1 = 5 reads 0x22 until the queue empties.
- Fill/full: six back-to-back ALU pushes with DEPTH = 4 and no drain stall → count never exceeds 4; alu_ready drops at count = 4 with free < 2 rules honored; free == 1 with ld_valid → only load accepted.
- Zero register: alu_addr = 0, data 0xFFFF_FFFF → handshake completes, count stays 0, rf_we stays 0, fwd1_hit = 0 for q_a1 = 0.
- Reset mid-drain: three entries queued, rst_n = 0 one edge → next cycle count = 0, rf_we = 0, no further writes issued.

Source files
------------

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: merges load/ALU register writes into one in-order RF write port with read forwarding
module rf_writeback_queue #(
    parameter int N     = 5,
    parameter int M     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_valid,
    input  logic [N-1:0]             ld_addr,
    input  logic [M-1:0]             ld_data,
    output logic                     ld_ready,
    input  logic                     alu_valid,
    input  logic [N-1:0]             alu_addr,
    input  logic [M-1:0]             alu_data,
    output logic                     alu_ready,
    output logic                     rf_we,
    output logic [N-1:0]             rf_a3,
    output logic [M-1:0]             rf_wd,
    input  logic [N-1:0]             q_a1,
    input  logic [N-1:0]             q_a2,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [M-1:0]             fwd1_data,
    output logic [M-1:0]             fwd2_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  addr_q [DEPTH];
    logic [M-1:0]  data_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d, free;
    logic          ld_push, alu_push, pop;

    always_comb begin
        free      = CW'(DEPTH) - count_q;
        ld_ready  = free >= CW'(1);
        alu_ready = free >= CW'(2) || (free == CW'(1) && !ld_valid);
        ld_push   = ld_valid && ld_ready && ld_addr != '0;
        alu_push  = alu_valid && alu_ready && alu_addr != '0;
        pop       = count_q != '0;
        head_d    = head_q + AW'(pop);
        tail_d    = tail_q + AW'(ld_push) + AW'(alu_push);
        count_d   = count_q + CW'(ld_push) + CW'(alu_push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // load is older than a same-cycle ALU result, so it takes the lower slot
    always_ff @(posedge clk) begin
        if (ld_push) begin
            addr_q[tail_q] <= ld_addr;
            data_q[tail_q] <= ld_data;
        end
        if (alu_push) begin
            addr_q[tail_q + AW'(ld_push)] <= alu_addr;
            data_q[tail_q + AW'(ld_push)] <= alu_data;
        end
    end

    assign rf_we = pop;
    assign rf_a3 = pop ? addr_q[head_q] : '0;
    assign rf_wd = pop ? data_q[head_q] : '0;
    assign count = count_q;

    // walk oldest to youngest so the last match wins
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && q_a1 != '0 && addr_q[head_q + AW'(i)] == q_a1) begin
                fwd1_hit  = 1'b1;
                fwd1_data = data_q[head_q + AW'(i)];
            end
            if (CW'(i) < count_q && q_a2 != '0 && addr_q[head_q + AW'(i)] == q_a2) begin
                fwd2_hit  = 1'b1;
                fwd2_data = data_q[head_q + AW'(i)];
            end
        end
    end
endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue: table-driven cycle vectors plus a scoreboard of expected register-file writes
module tb_rf_writeback_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid, alu_valid, ld_ready, alu_ready;
    logic [4:0]  ld_addr, alu_addr, q_a1, q_a2, rf_a3;
    logic [31:0] ld_data, alu_data, rf_wd, fwd1_data, fwd2_data;
    logic        rf_we, fwd1_hit, fwd2_hit;
    logic [2:0]  count;

    typedef struct {
        logic lv; logic [4:0] la; logic [31:0] ldat;
        logic av; logic [4:0] aa; logic [31:0] adat;
        logic [4:0] q1; logic [4:0] q2;
        logic [2:0] cnt; logic lr; logic ar; logic we; logic [4:0] a3; logic [31:0] wd;
        logic h1; logic [31:0] d1; logic h2; logic [31:0] d2;
    } vec_t;
    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;

    vec_t v [18];
    wr_t  sb [$];
    int   checks = 0;
    int   errors = 0;

    rf_writeback_queue #(.N(5), .M(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .q_a1(q_a1), .q_a2(q_a2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic lv, input logic [4:0] la, input logic [31:0] ldat,
                         input logic av, input logic [4:0] aa, input logic [31:0] adat,
                         input logic [4:0] q1, input logic [4:0] q2);
        @(negedge clk);
        ld_valid = lv; ld_addr = la; ld_data = ldat;
        alu_valid = av; alu_addr = aa; alu_data = adat;
        q_a1 = q1; q_a2 = q2;
        #1;
    endtask

    task automatic rf_mon(input string tag);
        wr_t w;
        if (rf_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_rf_unexpected: got write a3=%0d wd=%h expected no write", tag, rf_a3, rf_wd);
            end else begin
                w = sb.pop_front();
                chk({tag, "_rf_a3"}, 32'(rf_a3), 32'(w.a));
                chk({tag, "_rf_wd"}, rf_wd, w.d);
            end
        end
    endtask

    initial begin
        //        lv la  ldat      av aa  adat          q1 q2  cnt lr ar we a3  wd        h1 d1       h2 d2
        v[0]  = '{0, 0,  0,        0, 0,  0,            0, 0,  0,  1, 1, 0, 0,  0,        0, 0,       0, 0};
        v[1]  = '{0, 0,  0,        1, 3,  'hAA,         0, 0,  0,  1, 1, 0, 0,  0,        0, 0,       0, 0};
        v[2]  = '{0, 0,  0,        0, 0,  0,            3, 0,  1,  1, 1, 1, 3,  'hAA,     1, 'hAA,    0, 0};
        v[3]  = '{1, 5,  'h11,     1, 5,  'h22,         5, 0,  0,  1, 1, 0, 0,  0,        0, 0,       0, 0};
        v[4]  = '{0, 0,  0,        0, 0,  0,            5, 3,  2,  1, 1, 1, 5,  'h11,     1, 'h22,    0, 0};
        v[5]  = '{0, 0,  0,        0, 0,  0,            5, 0,  1,  1, 1, 1, 5,  'h22,     1, 'h22,    0, 0};
        v[6]  = '{0, 0,  0,        0, 0,  0,            5, 0,  0,  1, 1, 0, 0,  0,        0, 0,       0, 0};
        v[7]  = '{1, 1,  'h101,    1, 2,  'h102,        0, 0,  0,  1, 1, 0, 0,  0,        0, 0,       0, 0};
        v[8]  = '{1, 3,  'h103,    1, 4,  'h104,        2, 1,  2,  1, 1, 1, 1,  'h101,    1, 'h102,   1, 'h101};
        v[9]  = '{1, 6,  'h106,    1, 7,  'h107,        4, 0,  3,  1, 0, 1, 2,  'h102,    1, 'h104,   0, 0};
        v[10] = '{0, 0,  0,        1, 7,  'h107,        7, 0,  3,  1, 1, 1, 3,  'h103,    0, 0,       0, 0};
        v[11] = '{1, 8,  'h108,    1, 9,  'h109,        6, 0,  3,  1, 0, 1, 4,  'h104,    1, 'h106,   0, 0};
        v[12] = '{0, 0,  0,        1, 0,  'hFFFFFFFF,   0, 0,  3,  1, 1, 1, 6,  'h106,    0, 0,       0, 0};
        v[13] = '{1, 0,  'h55,     1, 10, 'h10A,        8, 0,  2,  1, 1, 1, 7,  'h107,    1, 'h108,   0, 0};
        v[14] = '{0, 0,  0,        0, 0,  0,            10, 8, 2,  1, 1, 1, 8,  'h108,    1, 'h10A,   1, 'h108};
        v[15] = '{0, 0,  0,        0, 0,  0,            0, 0,  1,  1, 1, 1, 10, 'h10A,    0, 0,       0, 0};
        v[16] = '{0, 0,  0,        1, 0,  'hFFFFFFFF,   0, 0,  0,  1, 1, 0, 0,  0,        0, 0,       0, 0};
        v[17] = '{0, 0,  0,        0, 0,  0,            0, 0,  0,  1, 1, 0, 0,  0,        0, 0,       0, 0};

        rst_n = 1'b0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        q_a1 = 0; q_a2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_fwd1_hit", 32'(fwd1_hit), 0);
        chk("rst_ld_ready", 32'(ld_ready), 1);
        chk("rst_alu_ready", 32'(alu_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(v[i].lv, v[i].la, v[i].ldat, v[i].av, v[i].aa, v[i].adat, v[i].q1, v[i].q2);
            chk($sformatf("r%0d_count", i), 32'(count), 32'(v[i].cnt));
            chk($sformatf("r%0d_ld_ready", i), 32'(ld_ready), 32'(v[i].lr));
            chk($sformatf("r%0d_alu_ready", i), 32'(alu_ready), 32'(v[i].ar));
            chk($sformatf("r%0d_rf_we", i), 32'(rf_we), 32'(v[i].we));
            chk($sformatf("r%0d_rf_a3", i), 32'(rf_a3), 32'(v[i].a3));
            chk($sformatf("r%0d_rf_wd", i), rf_wd, v[i].wd);
            chk($sformatf("r%0d_fwd1_hit", i), 32'(fwd1_hit), 32'(v[i].h1));
            chk($sformatf("r%0d_fwd1_data", i), fwd1_data, v[i].d1);
            chk($sformatf("r%0d_fwd2_hit", i), 32'(fwd2_hit), 32'(v[i].h2));
            chk($sformatf("r%0d_fwd2_data", i), fwd2_data, v[i].d2);
            rf_mon($sformatf("r%0d", i));
            if (v[i].lv && v[i].lr && v[i].la != 0) sb.push_back('{v[i].la, v[i].ldat});
            if (v[i].av && v[i].ar && v[i].aa != 0) sb.push_back('{v[i].aa, v[i].adat});
        end
        chk("table_sb_drained", 32'(sb.size()), 0);

        // reset while three writes are pending
        drive(1, 11, 'hA1, 1, 12, 'hA2, 0, 0);
        chk("mr_count0", 32'(count), 0);
        rf_mon("mr0");
        sb.push_back('{5'd11, 32'hA1});
        sb.push_back('{5'd12, 32'hA2});
        drive(1, 13, 'hA3, 1, 14, 'hA4, 0, 0);
        chk("mr_count1", 32'(count), 2);
        rf_mon("mr1");
        sb.push_back('{5'd13, 32'hA3});
        sb.push_back('{5'd14, 32'hA4});
        drive(0, 0, 0, 0, 0, 0, 13, 14);
        chk("mr_count2", 32'(count), 3);
        chk("mr_fwd1_hit", 32'(fwd1_hit), 1);
        chk("mr_fwd2_data", fwd2_data, 'hA4);
        rf_mon("mr2");
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 13, 14);
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mr_post%0d_count", i), 32'(count), 0);
            chk($sformatf("mr_post%0d_rf_we", i), 32'(rf_we), 0);
            chk($sformatf("mr_post%0d_fwd1_hit", i), 32'(fwd1_hit), 0);
            rf_mon($sformatf("mr_post%0d", i));
            drive(0, 0, 0, 0, 0, 0, 13, 14);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
